// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage; mult/div run for a fixed cycle count.
// Optional msub (md_op=9) is built only when MDU_MSUB_EN is defined.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU = 4'd4,
    OP_MTHI  = 4'd5, OP_MTLO = 4'd6, OP_MFHI  = 4'd7, OP_MFLO = 4'd8, OP_MSUB = 4'd9
  } op_e;

`ifdef MDU_MSUB_EN
  localparam bit MSUB_EN = 1'b1;
`else
  localparam bit MSUB_EN = 1'b0;
`endif

  state_e      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] op_a, op_b;

  logic [63:0] prod_s, prod_u, res;
  logic [31:0] a_mag, b_mag, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic        is_mul, is_div;

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU) || (MSUB_EN && (md_op == OP_MSUB));
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 naturally.
  always_comb begin
    prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    prod_u = {32'd0, op_a} * {32'd0, op_b};
    a_mag  = op_a[31] ? -op_a : op_a;
    b_mag  = op_b[31] ? -op_b : op_b;
    mag_q  = a_mag / b_mag;
    mag_r  = a_mag % b_mag;
    sdiv_q = (op_a[31] ^ op_b[31]) ? -mag_q : mag_q;
    sdiv_r = op_a[31] ? -mag_r : mag_r;
    udiv_q = op_a / op_b;
    udiv_r = op_a % op_b;
    res    = {hi, lo};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (op_b != '0) res = {sdiv_r, sdiv_q};
      OP_DIVU:  if (op_b != '0) res = {udiv_r, udiv_q};
`ifdef MDU_MSUB_EN
      OP_MSUB:  res = {hi, lo} - prod_s;
`endif
      default:  res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              op_q  <= md_op;
              op_a  <= A;
              op_b  <= B;
              busy  <= 1'b1;
              state <= is_mul ? MUL : DIV;
              cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end else if (md_op == OP_MTHI) begin
              hi <= A;
            end else if (md_op == OP_MTLO) begin
              lo <= A;
            end
          end
        end
        MUL, DIV: begin
          if (cnt == 4'd1) begin
            {hi, lo} <= res;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    md_out = '0;
    if (md_op == OP_MFHI) md_out = hi;
    else if (md_op == OP_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int compared = 0;
  int mismatched = 0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one op, counts busy cycles (bounded), checks results.
  task automatic run_op(input vec_t v);
    int n;
    md_op = v.op; A = v.a; B = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = '0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({v.name, " busy_cycles"}, 32'(n), 32'(v.n));
    check({v.name, " hi"}, hi, v.hi);
    check({v.name, " lo"}, lo, v.lo);
  endtask

  initial begin
    logic [31:0] ms_hi, ms_lo;
    int ms_n, n;
`ifdef MDU_MSUB_EN
    ms_n = 5; ms_hi = 32'hFFFFFFFF; ms_lo = 32'hFFFFFFFE;
`else
    ms_n = 0; ms_hi = 32'h0; ms_lo = 32'hA;
`endif
    vecs[0]  = '{"mult_m1x2",    4'd1, 32'hFFFFFFFF, 32'h2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_m1x2",   4'd2, 32'hFFFFFFFF, 32'h2,        5,  32'h1,        32'hFFFFFFFE};
    vecs[2]  = '{"mult_neg_neg", 4'd1, 32'hFFFFFFFD, 32'hFFFFFFFC, 5,  32'h0,        32'hC};
    vecs[3]  = '{"multu_carry",  4'd2, 32'h80000000, 32'h2,        5,  32'h1,        32'h0};
    vecs[4]  = '{"div_m7_2",     4'd3, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{"div_7_m2",     4'd3, 32'h7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD};
    vecs[6]  = '{"divu_7_2",     4'd4, 32'h7,        32'h2,        10, 32'h1,        32'h3};
    vecs[7]  = '{"divu_big",     4'd4, 32'hFFFFFFFF, 32'h10,       10, 32'hF,        32'h0FFFFFFF};
    vecs[8]  = '{"div_ovf",      4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000};
    vecs[9]  = '{"mthi_11",      4'd5, 32'h11,       32'h0,        0,  32'h11,       32'h80000000};
    vecs[10] = '{"mtlo_22",      4'd6, 32'h22,       32'h0,        0,  32'h11,       32'h22};
    vecs[11] = '{"div_by0",      4'd3, 32'h5,        32'h0,        10, 32'h11,       32'h22};
    vecs[12] = '{"divu_by0",     4'd4, 32'h5,        32'h0,        10, 32'h11,       32'h22};
    vecs[13] = '{"mthi_0",       4'd5, 32'h0,        32'h0,        0,  32'h0,        32'h22};
    vecs[14] = '{"mtlo_10",      4'd6, 32'hA,        32'h0,        0,  32'h0,        32'hA};
    vecs[15] = '{"msub_3x4",     4'd9, 32'h3,        32'h4,        ms_n, ms_hi,      ms_lo};
    vecs[16] = '{"mfhi_noop",    4'd7, 32'h77,       32'h0,        0,  ms_hi,        ms_lo};
    vecs[17] = '{"undef_op",     4'd15, 32'h77,      32'h0,        0,  ms_hi,        ms_lo};
    vecs[18] = '{"mult_m1xm1",   4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h0,        32'h1};

    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the 2nd busy cycle of a mult must clear everything and suppress the result.
    md_op = 4'd5; A = 32'h55; start = 1'b1;
    @(negedge clk);
    md_op = 4'd1; A = 32'h3; B = 32'h3;
    @(negedge clk);
    start = 1'b0; md_op = '0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid hi", hi, 32'h0);
    check("rst_mid lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_after busy", 32'(busy), 32'd0);
    check("rst_after hi", hi, 32'h0);
    check("rst_after lo", lo, 32'h0);

    // Starts during a busy window are ignored, including mthi.
    md_op = 4'd1; A = 32'h2; B = 32'h3; start = 1'b1;
    @(negedge clk);
    n = busy ? 1 : 0;
    md_op = 4'd2; A = 32'h5; B = 32'h7;
    @(negedge clk);
    if (busy) n++;
    md_op = 4'd5; A = 32'h99;
    @(negedge clk);
    start = 1'b0; md_op = '0;
    check("ign mthi hi", hi, 32'h0);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ign busy_cycles", 32'(n), 32'd5);
    check("ign hi", hi, 32'h0);
    check("ign lo", lo, 32'h6);
    md_op = 4'd7; #1;
    check("mfhi md_out", md_out, 32'h0);
    md_op = 4'd8; #1;
    check("mflo md_out", md_out, 32'h6);
    md_op = 4'd0; #1;
    check("none md_out", md_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multiply/divide unit with HI/LO registers, located in the E stage beside the ALU. It executes mult, multu, div, divu and msub over a fixed number of cycles. It executes mthi/mtlo writes and mfhi/mflo reads in a single cycle. Its `busy` output is the `alubusy` input consumed by the D-stage stall logic, which also stalls while E holds a multi-cycle op.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu/msub (1..15)
- `DIV_CYCLES`, 10: busy cycles for div/divu (1..15)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  E-stage instruction is an MDU op and is valid this cycle
- `md_op`  in  4  encoding:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 msub
  - any other value is a no-op
- `A`  in  32  forwarded rs value
- `B`  in  32  forwarded rt value
- `busy`  out  1  a multi-cycle op is in progress
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `md_out`  out  32  combinational read value: `hi` when `md_op`=7, `lo` when `md_op`=8, otherwise 0

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0, operand latches 0.
- States are IDLE, MUL and DIV.
- IDLE with `start`=1:
  - mult, multu, msub: latch `A`, `B` and the op, load the counter with `MULT_CYCLES`, go to MUL.
  - div, divu: latch operands and op, load the counter with `DIV_CYCLES`, go to DIV.
  - mthi: `hi`<=`A` at this edge; stay IDLE; `busy` stays 0.
  - mtlo: `lo`<=`A` at this edge; stay IDLE; `busy` stays 0.
  - mfhi, mflo, none, undefined: no state change.
- MUL/DIV: the counter decrements each cycle. When it reaches 1, on that edge:
  - write the result into `hi`/`lo`;
  - return to IDLE;
  - deassert `busy`.
- Arithmetic, all 64-bit intermediate:
  - mult: {hi,lo} = signed(A) × signed(B).
  - multu: {hi,lo} = unsigned(A) × unsigned(B).
  - msub: {hi,lo} = {hi,lo} − signed(A) × signed(B). Uses the `hi`/`lo` values present at completion; they cannot change while busy.
  - div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - div overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - B=0 for div/divu: full busy duration, then `hi`/`lo` are left unchanged.
- `start` while `busy`=1: ignored for every op, mthi/mtlo included. No latch, no write, no restart.
- `md_out` is combinational from `md_op`, `hi` and `lo` regardless of `start` or `busy`. The stall logic guarantees mfhi/mflo never reach E while busy.

## Timing
- Single clock domain.
- Start at cycle t:
  - `busy` is high in cycles t+1 .. t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New `hi`/`lo` are visible from cycle t+N+1, the same cycle `busy` returns to 0.
- A back-to-back start in cycle t+N+1 is accepted.
- mthi/mtlo: the value is visible in `hi`/`lo` from cycle t+1.
- Reset asserted mid-operation: `busy`, `hi`, `lo` and the counter clear immediately (asynchronously). No result is written afterwards. The first edge after release sees IDLE.
- `busy` is a registered output, with no combinational path from `start`. The D-stage stall logic covers the start cycle itself by decoding E-stage ops.

## Configuration
- `MDU_MSUB_EN` defined:
  - `md_op`=9 executes msub as above.
- Undefined:
  - `md_op`=9 is treated as a no-op: no busy, no latch, no `hi`/`lo` write.
  - The 64-bit subtract path is not built.

## Test plan
- mult A=0xFFFFFFFF B=2 at t:
  - `busy`=1 for t+1..t+5, `busy`=0 at t+6.
  - At t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - The same operands via multu give hi=0x00000001, lo=0xFFFFFFFE.
- Divide, 10 busy cycles each:
  - div A=0xFFFFFFF9 (−7), B=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu A=7, B=2: lo=3, hi=1.
  - div A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi 0x11 then mtlo 0x22:
  - Each is visible the next cycle with no `busy`.
  - Then div A=5 B=0: `busy` for 10 cycles, and afterwards hi=0x11, lo=0x22.
- msub with hi=0, lo=10 and A=3, B=4:
  - With `MDU_MSUB_EN`: after 5 busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Without it: `busy` stays 0 and hi=0, lo=10 are unchanged.
- Reset mid-operation: mult A=3 B=3, then `reset` pulsed in the 2nd busy cycle.
  - `busy`, `hi` and `lo` are 0 immediately.
  - They are still 0 five cycles later.
- Start and mthi while busy, then reads:
  - During a mult (A=2, B=3) busy window, present `start` with multu and with mthi A=0x99.
  - Both are ignored: the mult finishes on schedule with hi=0, lo=6.
  - Afterwards `md_op`=7 gives `md_out`=0 and `md_op`=8 gives `md_out`=6, combinationally in the same cycle.
